// File: rtl/mips_instr_pkg.sv
// Shared MIPS encoding constants: opcodes, field bit positions and the
// instruction-class enum used by the decode queue.
package mips_instr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_COP0  = 6'h10;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNC_MSB  = 5;
  localparam int FUNC_LSB  = 0;
  localparam int IMM16_MSB = 15;
  localparam int IMM26_MSB = 25;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_J,
    CLS_COP0
  } instr_cls_e;

endpackage

// File: rtl/instr_field_split.sv
// Combinational MIPS field slicer: fields, sign/zero-extended imm16, class.
// Zero latency; no handshake.
module instr_field_split
  import mips_instr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [5:0]      o_op,
  output logic [4:0]      o_rs,
  output logic [4:0]      o_rt,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_shamt,
  output logic [5:0]      o_func,
  output logic [15:0]     o_imm16,
  output logic [25:0]     o_imm26,
  output logic [XLEN-1:0] o_imm_sext,
  output logic [XLEN-1:0] o_imm_zext,
  output instr_cls_e      o_cls
);

  assign o_op    = i_instr[OP_MSB:OP_LSB];
  assign o_rs    = i_instr[RS_MSB:RS_LSB];
  assign o_rt    = i_instr[RT_MSB:RT_LSB];
  assign o_rd    = i_instr[RD_MSB:RD_LSB];
  assign o_shamt = i_instr[SHAMT_MSB:SHAMT_LSB];
  assign o_func  = i_instr[FUNC_MSB:FUNC_LSB];
  assign o_imm16 = i_instr[IMM16_MSB:0];
  assign o_imm26 = i_instr[IMM26_MSB:0];

  assign o_imm_sext = {{(XLEN-16){i_instr[IMM16_MSB]}}, i_instr[IMM16_MSB:0]};
  assign o_imm_zext = {{(XLEN-16){1'b0}}, i_instr[IMM16_MSB:0]};

  always_comb begin
    o_cls = CLS_I;
    case (o_op)
      OP_RTYPE:     o_cls = CLS_R;
      OP_J, OP_JAL: o_cls = CLS_J;
      OP_COP0:      o_cls = CLS_COP0;
      default:      o_cls = CLS_I;
    endcase
  end

endmodule

// File: rtl/instr_decode_queue.sv
// DEPTH-entry {pc,instr} FIFO between fetch and register read; head is decoded
// combinationally. Push-to-head latency 1 cycle, no bypass; in_ready depends only on count.
module instr_decode_queue
  import mips_instr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PCW   = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PCW-1:0]  in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PCW-1:0]  out_pc,
  output logic [5:0]      op,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      func,
  output logic [15:0]     imm16,
  output logic [25:0]     imm26,
  output logic [XLEN-1:0] imm_sext,
  output logic [XLEN-1:0] imm_zext,
  output logic            is_rtype,
  output logic            is_itype,
  output logic            is_jtype,
  output logic            is_cop0
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [PCW-1:0] r_mem_pc    [DEPTH];
  logic [31:0]    r_mem_instr [DEPTH];

  logic w_push;
  logic w_pop;

  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);

  // flush wins over both handshakes so a redirect never leaves stale state
  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= in_pc;
      r_mem_instr[r_wr_ptr] <= in_instr;
    end
  end

  logic [PCW-1:0]  w_head_pc;
  logic [31:0]     w_head_instr;
  logic [5:0]      w_op;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [4:0]      w_shamt;
  logic [5:0]      w_func;
  logic [15:0]     w_imm16;
  logic [25:0]     w_imm26;
  logic [XLEN-1:0] w_imm_sext;
  logic [XLEN-1:0] w_imm_zext;
  instr_cls_e      w_cls;

  assign w_head_pc    = r_mem_pc[r_rd_ptr];
  assign w_head_instr = r_mem_instr[r_rd_ptr];

  instr_field_split #(.XLEN(XLEN)) u_split (
    .i_instr    (w_head_instr),
    .o_op       (w_op),
    .o_rs       (w_rs),
    .o_rt       (w_rt),
    .o_rd       (w_rd),
    .o_shamt    (w_shamt),
    .o_func     (w_func),
    .o_imm16    (w_imm16),
    .o_imm26    (w_imm26),
    .o_imm_sext (w_imm_sext),
    .o_imm_zext (w_imm_zext),
    .o_cls      (w_cls)
  );

  // an empty queue must present all-zero decode, whatever stale storage holds
  assign out_pc   = out_valid ? w_head_pc  : '0;
  assign op       = out_valid ? w_op       : '0;
  assign rs       = out_valid ? w_rs       : '0;
  assign rt       = out_valid ? w_rt       : '0;
  assign rd       = out_valid ? w_rd       : '0;
  assign shamt    = out_valid ? w_shamt    : '0;
  assign func     = out_valid ? w_func     : '0;
  assign imm16    = out_valid ? w_imm16    : '0;
  assign imm26    = out_valid ? w_imm26    : '0;
  assign imm_sext = out_valid ? w_imm_sext : '0;
  assign imm_zext = out_valid ? w_imm_zext : '0;

  assign is_rtype = out_valid && (w_cls == CLS_R);
  assign is_itype = out_valid && (w_cls == CLS_I);
  assign is_jtype = out_valid && (w_cls == CLS_J);
  assign is_cop0  = out_valid && (w_cls == CLS_COP0);

endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: queue-based reference model plus a negedge
// monitor comparing every output each cycle, with directed and random stimulus.
module tb_instr_decode_queue;

  localparam int DEPTH = 2;
  localparam int PCW   = 32;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [PCW-1:0]  in_pc;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [PCW-1:0]  out_pc;
  logic [5:0]      op;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [4:0]      shamt;
  logic [5:0]      func;
  logic [15:0]     imm16;
  logic [25:0]     imm26;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] imm_zext;
  logic            is_rtype;
  logic            is_itype;
  logic            is_jtype;
  logic            is_cop0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_decode_queue #(.DEPTH(DEPTH), .PCW(PCW), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .func      (func),
    .imm16     (imm16),
    .imm26     (imm26),
    .imm_sext  (imm_sext),
    .imm_zext  (imm_zext),
    .is_rtype  (is_rtype),
    .is_itype  (is_itype),
    .is_jtype  (is_jtype),
    .is_cop0   (is_cop0)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t exp_q[$];

  // Reference model: an ordered list of accepted words.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (exp_q.size() < DEPTH);
      do_pop  = out_ready && (exp_q.size() > 0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back('{pc: in_pc, instr: in_instr});
    end
  end

  function automatic logic [175:0] ref_vec(bit vld, bit rdy, logic [31:0] pc_i, logic [31:0] ins_i);
    logic [31:0] ins, pc, e_op, e_rs, e_rt, e_rd, e_sh, e_fn, e_i16, e_i26, e_sx;
    bit c_r, c_i, c_j, c_c;
    ins   = vld ? ins_i : 32'd0;
    pc    = vld ? pc_i  : 32'd0;
    e_op  = ins >> 26;
    e_rs  = (ins >> 21) % 32;
    e_rt  = (ins >> 16) % 32;
    e_rd  = (ins >> 11) % 32;
    e_sh  = (ins >> 6) % 32;
    e_fn  = ins % 64;
    e_i16 = ins % 65536;
    e_i26 = ins % 67108864;
    e_sx  = (e_i16 >= 32768) ? e_i16 + 32'hFFFF0000 : e_i16;
    c_r   = vld && (e_op == 0);
    c_j   = vld && (e_op == 2 || e_op == 3);
    c_c   = vld && (e_op == 16);
    c_i   = vld && !c_r && !c_j && !c_c;
    return {vld, rdy, pc, e_op[5:0], e_rs[4:0], e_rt[4:0], e_rd[4:0], e_sh[4:0],
            e_fn[5:0], e_i16[15:0], e_i26[25:0], e_sx, e_i16, c_r, c_i, c_j, c_c};
  endfunction

  wire [175:0] act_vec = {out_valid, in_ready, out_pc, op, rs, rt, rd, shamt, func,
                          imm16, imm26, imm_sext, imm_zext, is_rtype, is_itype, is_jtype, is_cop0};

  // Monitor: compares the DUT against the model head every cycle.
  always @(negedge clk) begin
    logic [175:0] e;
    int sz;
    sz = exp_q.size();
    if (rst || sz == 0) e = ref_vec(1'b0, 1'b1, 32'd0, 32'd0);
    else e = ref_vec(1'b1, sz != DEPTH, exp_q[0].pc, exp_q[0].instr);
    n_tests++;
    if (act_vec !== e) begin
      n_fail++;
      $display("FAIL monitor t=%0t got %h expected %h", $time, act_vec, e);
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(bit v, logic [31:0] pc, logic [31:0] ins, bit ordy, bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ins;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_decode_zero", 64'({op, imm26, imm_sext, out_pc}), 64'd0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // lw $t0,-4($at)
    step(1, 32'h0040_0000, 32'h8C28_FFFC, 0, 0);
    chk("lw_valid", 64'(out_valid), 64'd1);
    chk("lw_pc", 64'(out_pc), 64'h40_0000);
    chk("lw_op", 64'(op), 64'h23);
    chk("lw_rs", 64'(rs), 64'd1);
    chk("lw_rt", 64'(rt), 64'd8);
    chk("lw_imm16", 64'(imm16), 64'hFFFC);
    chk("lw_sext", 64'(imm_sext), 64'hFFFF_FFFC);
    chk("lw_zext", 64'(imm_zext), 64'h0000_FFFC);
    chk("lw_itype", 64'({is_rtype, is_itype, is_jtype, is_cop0}), 64'b0100);
    step(0, 0, 0, 1, 0);
    chk("lw_popped", 64'(out_valid), 64'd0);

    // add then jal, with downstream stalled
    step(1, 32'h0040_0004, 32'h012A_4020, 0, 0);
    step(1, 32'h0040_0008, 32'h0C10_0004, 0, 0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("add_fields", 64'({rs, rt, rd, shamt, func}), 64'({5'd9, 5'd10, 5'd8, 5'd0, 6'h20}));
    chk("add_rtype", 64'({is_rtype, is_itype, is_jtype, is_cop0}), 64'b1000);
    step(0, 0, 0, 1, 0);
    chk("jal_op", 64'(op), 64'd3);
    chk("jal_imm26", 64'(imm26), 64'h010_0004);
    chk("jal_jtype", 64'({is_rtype, is_itype, is_jtype, is_cop0}), 64'b0010);
    step(0, 0, 0, 1, 0);
    chk("drain_empty", 64'(out_valid), 64'd0);

    // steady push+pop at count 1 across pointer wrap
    step(1, 32'h1000_0000, $urandom, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      step(1, 32'h1000_0000 + 32'(4 * k), $urandom, 1, 0);
      chk("steady_count1", 64'({out_valid, in_ready}), 64'b11);
      chk("steady_order", 64'(out_pc), 64'(32'h1000_0000 + 32'(4 * k)));
    end
    step(0, 0, 0, 1, 0);
    chk("steady_drain", 64'(out_valid), 64'd0);

    // flush while full with a concurrent offer
    step(1, 32'h0000_2000, 32'h2402_0001, 0, 0);
    step(1, 32'h0000_2004, 32'h2402_0002, 0, 0);
    step(1, 32'hDEAD_0000, 32'h2402_0007, 1, 1);
    chk("flush_empty", 64'({out_valid, in_ready}), 64'b01);
    chk("flush_pc_zero", 64'(out_pc), 64'd0);
    step(1, 32'h0050_0000, 32'h2402_0005, 0, 0);
    chk("post_flush_pc", 64'(out_pc), 64'h50_0000);
    chk("post_flush_imm", 64'(imm16), 64'd5);
    step(1, 32'hBEEF_0000, 32'h2402_0009, 1, 1);
    chk("flush_drops_offer", 64'(out_valid), 64'd0);
    step(0, 0, 0, 0, 0);
    chk("flush_still_empty", 64'(out_valid), 64'd0);

    // mtc0 $zero,$12
    step(1, 32'h0060_0000, 32'h4080_6000, 0, 0);
    chk("mtc0_class", 64'({is_rtype, is_itype, is_jtype, is_cop0}), 64'b0001);
    chk("mtc0_rt_rd", 64'({rt, rd}), 64'({5'd0, 5'd12}));

    // asynchronous reset mid-stream
    step(1, 32'h0060_0004, 32'h0000_0000, 0, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", 64'({out_valid, in_ready, op, rt, rd}), 64'({1'b0, 1'b1, 6'd0, 5'd0, 5'd0}));
    @(posedge clk);
    #1;
    chk("rst_held_outputs", 64'({out_valid, in_ready, out_pc}), 64'({1'b0, 1'b1, 32'd0}));
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("after_rst_empty", 64'(out_valid), 64'd0);

    // random traffic checked by the monitor
    for (int c = 0; c < 400; c++) begin
      ins = $urandom;
      case ($urandom % 6)
        0: ins[31:26] = 6'h00;
        1: ins[31:26] = 6'h02;
        2: ins[31:26] = 6'h03;
        3: ins[31:26] = 6'h10;
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, $urandom, ins, ($urandom % 2) != 0, ($urandom % 20) == 0);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
